spec_vector_mw: RTL and testbench
=================================

Name: spec_vector_mw

Overview:
- Next-generation branch-speculation tracker. It holds up to SPEC_DEPTH outstanding speculative branches in age order, with the oldest entry at index 0 and entry i at spec level i+1.
- It resolves up to NUM_WB condition-register write-backs per cycle, where the previous generation handled one.
- It adds push back-pressure (br_rdy) and a global flush.
- It sits between issue (branch push) and the register write-back bus. Its outputs drive level renumbering and rollback in the scoreboard and fetch.

Parameters:
- NUM_TAG, 4, rename tags per rollback tag map
- NUM_REG, 8, architectural registers
- SPEC_DEPTH, 4, maximum outstanding speculative branches
- NUM_WB, 2, condition write-back channels per cycle
- PC_BIT, 4, rollback PC width
- INST_ID_BIT, 8, instruction id width
- REG_ID_BIT, clog2(NUM_REG), register id width
- SPEC_LEVEL_BIT, clog2(SPEC_DEPTH)+1, spec level width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  drop all entries next edge
- br_vld  in  1  push request
- br_rdy  out  1  push accepted when br_vld&&br_rdy
- br_cond_reg  in  REG_ID_BIT  condition register
- br_cond_predicted_val  in  1  predicted value
- br_rollback_pc  in  PC_BIT  rollback PC
- br_rollback_id  in  INST_ID_BIT  rollback instruction id
- br_rollback_tag_map  in  NUM_TAG*REG_ID_BIT  rollback tag map
- cond_wb_vld  in  NUM_WB  per-channel write-back valid
- cond_wb_reg  in  NUM_WB*REG_ID_BIT  per-channel register
- cond_wb_val  in  NUM_WB  per-channel value
- cur_spec_level  out  SPEC_LEVEL_BIT  spec level of instructions executing this cycle
- br_pred_succ_vld  out  1  at least one entry resolved correctly this cycle
- br_pred_succ_nxt_levels  out  SPEC_LEVEL_BIT*(SPEC_DEPTH+1)  old level -> new level map; slot 0 is always 0
- br_pred_fail  out  1  mispredict this cycle
- br_pred_fail_level  out  SPEC_LEVEL_BIT  levels >= this roll back
- br_pred_fail_tag_map  out  NUM_TAG*REG_ID_BIT  tag map of the failing entry
- br_pred_fail_pc  out  PC_BIT  rollback PC of the failing entry
- br_pred_fail_id  out  INST_ID_BIT  rollback instruction id of the failing entry

Behaviour:
- Matching:
  - Entry e matches channel c when entry_vld[e], cond_wb_vld[c], and cond_reg[e]==cond_wb_reg[c].
  - If several channels carry the same register, the lowest channel index wins.
  - A matched entry is "ok" when its pred_val equals the winning channel's value, otherwise "bad".
- Fail:
  - f = lowest index of any bad entry.
  - br_pred_fail=1, br_pred_fail_level=f+1, and the fail_pc/id/tag_map come from entry f.
  - All entries >= f are invalid next cycle.
  - When there is no fail, the fail data outputs are don't-care and br_pred_fail_level is 0.
- Success:
  - Ok entries below f (or below SPEC_DEPTH when there is no fail) are removed.
  - Survivors compact toward index 0 with order preserved.
  - nxt_levels[k+1] = number of survivors at indices <= k if entry k survives; otherwise don't-care.
  - All resolution outputs are combinational, same cycle.
- cur_spec_level = survivor count after this cycle's resolution, before any push.
- br_rdy = ~br_pred_fail & ~flush & (survivor count < SPEC_DEPTH).
  - This means a push is accepted in the same cycle a success frees a full stack.
  - A push into a full stack with no success is refused and state is unchanged.
- Accepted push is written at index = survivor count and becomes visible next cycle.
  - It is not matched against this cycle's write-backs. Write-back of its register in the push cycle is the issuer's responsibility (do not push).
- flush, when 1, has priority over everything: all entry_vld go to 0 next edge. The resolution outputs still reflect the current contents.
- Reset (rst_n=0 at an edge): entry_vld=0, which gives cur_spec_level=0, br_rdy=1, br_pred_fail=0 and br_pred_succ_vld=0.
  - Reset during a pending fail discards the fail.
  - Payload registers are not reset.
- Idle (no matches, no push): state holds.

Decomposition:
- Shared package/header: SPEC_LEVEL_BIT derivation and the entry payload packing offsets (cond_reg, pred_val, pc, id, tag_map).
- Reuse the existing compact, prefix_sum and leading_zero_one_cnt modules.
- One new sub-module, spec_wb_match: per-entry match/ok/bad vectors across NUM_WB channels with lowest-channel priority.

Test Plan:
- Push r1 (pred 1), r2 (pred 0); wb ch0 r1=1 -> succ_vld=1, nxt_levels[2]=1, next cycle cur_spec_level=1, entry0.cond_reg=r2.
- 4 entries r1,r2,r3,r4 all pred 1; ch0 r2=1, ch1 r4=1 in one cycle -> nxt_levels[1]=1, nxt_levels[3]=2, cur_spec_level=2, entries r1,r3.
- Same 4 entries; ch0 r3=0, ch1 r1=1 -> fail=1, fail_level=3, fail_pc from entry2, remaining entry r2 at level 1.
- Full stack (4), br_vld=1, no wb -> br_rdy=0, contents unchanged; same cycle with ch0 resolving entry0 ok -> br_rdy=1, cur_spec_level=3, new entry at index 3.
- ch0 and ch1 both r2, values 1 and 0, entry pred 1 -> ch0 wins, success, no fail.
- flush=1 with 3 entries and simultaneous push -> br_rdy=0, next cycle cur_spec_level=0; rst_n=0 mid-fail -> br_pred_fail=0 next cycle.

Source files
------------

// File: rtl/spec_vector_mw_pkg.sv
// Shared widths and entry payload layout for the speculative branch tracker.
package spec_vector_mw_pkg;

    localparam int unsigned NUM_TAG        = 4;
    localparam int unsigned NUM_REG        = 8;
    localparam int unsigned SPEC_DEPTH     = 4;
    localparam int unsigned NUM_WB         = 2;
    localparam int unsigned PC_BIT         = 4;
    localparam int unsigned INST_ID_BIT    = 8;
    localparam int unsigned REG_ID_BIT     = $clog2(NUM_REG);
    localparam int unsigned IDX_BIT        = $clog2(SPEC_DEPTH);
    localparam int unsigned SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1;
    localparam int unsigned TAG_MAP_BIT    = NUM_TAG * REG_ID_BIT;

    localparam int unsigned COND_REG_LSB = 0;
    localparam int unsigned PRED_VAL_LSB = COND_REG_LSB + REG_ID_BIT;
    localparam int unsigned PC_LSB       = PRED_VAL_LSB + 1;
    localparam int unsigned ID_LSB       = PC_LSB + PC_BIT;
    localparam int unsigned TAG_MAP_LSB  = ID_LSB + INST_ID_BIT;
    localparam int unsigned ENTRY_BIT    = TAG_MAP_LSB + TAG_MAP_BIT;

    typedef logic [ENTRY_BIT-1:0] entry_t;

    // Concatenation order must mirror the *_LSB offsets above.
    function automatic entry_t pack_entry(input logic [REG_ID_BIT-1:0]  cond_reg,
                                          input logic                   pred_val,
                                          input logic [PC_BIT-1:0]      pc,
                                          input logic [INST_ID_BIT-1:0] id,
                                          input logic [TAG_MAP_BIT-1:0] tag_map);
        return {tag_map, id, pc, pred_val, cond_reg};
    endfunction

endpackage

// File: rtl/spec_vector_mw_if.sv
// Push, write-back and resolution bundle between issue, write-back bus and the tracker.
interface spec_vector_mw_if;
    import spec_vector_mw_pkg::*;

    logic                                      flush;
    logic                                      br_vld;
    logic                                      br_rdy;
    logic [REG_ID_BIT-1:0]                     br_cond_reg;
    logic                                      br_cond_predicted_val;
    logic [PC_BIT-1:0]                         br_rollback_pc;
    logic [INST_ID_BIT-1:0]                    br_rollback_id;
    logic [TAG_MAP_BIT-1:0]                    br_rollback_tag_map;
    logic [NUM_WB-1:0]                         cond_wb_vld;
    logic [NUM_WB*REG_ID_BIT-1:0]              cond_wb_reg;
    logic [NUM_WB-1:0]                         cond_wb_val;
    logic [SPEC_LEVEL_BIT-1:0]                 cur_spec_level;
    logic                                      br_pred_succ_vld;
    logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0]  br_pred_succ_nxt_levels;
    logic                                      br_pred_fail;
    logic [SPEC_LEVEL_BIT-1:0]                 br_pred_fail_level;
    logic [TAG_MAP_BIT-1:0]                    br_pred_fail_tag_map;
    logic [PC_BIT-1:0]                         br_pred_fail_pc;
    logic [INST_ID_BIT-1:0]                    br_pred_fail_id;

    modport master (
        output flush, br_vld, br_cond_reg, br_cond_predicted_val, br_rollback_pc,
               br_rollback_id, br_rollback_tag_map, cond_wb_vld, cond_wb_reg, cond_wb_val,
        input  br_rdy, cur_spec_level, br_pred_succ_vld, br_pred_succ_nxt_levels,
               br_pred_fail, br_pred_fail_level, br_pred_fail_tag_map, br_pred_fail_pc,
               br_pred_fail_id
    );

    modport slave (
        input  flush, br_vld, br_cond_reg, br_cond_predicted_val, br_rollback_pc,
               br_rollback_id, br_rollback_tag_map, cond_wb_vld, cond_wb_reg, cond_wb_val,
        output br_rdy, cur_spec_level, br_pred_succ_vld, br_pred_succ_nxt_levels,
               br_pred_fail, br_pred_fail_level, br_pred_fail_tag_map, br_pred_fail_pc,
               br_pred_fail_id
    );

endinterface

// File: rtl/spec_wb_match.sv
// Per-entry ok/bad classification against all write-back channels.
module spec_wb_match
    import spec_vector_mw_pkg::*;
(
    input  logic [SPEC_DEPTH-1:0]        entry_vld,
    input  logic [REG_ID_BIT-1:0]        cond_reg [SPEC_DEPTH],
    input  logic [SPEC_DEPTH-1:0]        pred_val,
    input  logic [NUM_WB-1:0]            wb_vld,
    input  logic [NUM_WB*REG_ID_BIT-1:0] wb_reg,
    input  logic [NUM_WB-1:0]            wb_val,
    output logic [SPEC_DEPTH-1:0]        ok,
    output logic [SPEC_DEPTH-1:0]        bad
);

    logic [SPEC_DEPTH-1:0] hit;
    logic [SPEC_DEPTH-1:0] hit_val;

    always_comb begin
        hit     = '0;
        hit_val = '0;
        ok      = '0;
        bad     = '0;
        for (int e = 0; e < SPEC_DEPTH; e++) begin
            // Walk channels high to low so the lowest matching channel is written last.
            for (int c = NUM_WB - 1; c >= 0; c--) begin
                if (entry_vld[e] && wb_vld[c] &&
                    cond_reg[e] == wb_reg[c*REG_ID_BIT +: REG_ID_BIT]) begin
                    hit[e]     = 1'b1;
                    hit_val[e] = wb_val[c];
                end
            end
            ok[e]  = hit[e] & (hit_val[e] == pred_val[e]);
            bad[e] = hit[e] & (hit_val[e] != pred_val[e]);
        end
    end

endmodule

// File: rtl/spec_vector_mw.sv
// Age-ordered speculative branch stack with multi-channel resolution, compaction and push.
module spec_vector_mw
    import spec_vector_mw_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    spec_vector_mw_if.slave bus
);

    logic [SPEC_DEPTH-1:0]                    vld_q, vld_d;
    entry_t                                   payload_q [SPEC_DEPTH];
    entry_t                                   payload_d [SPEC_DEPTH];
    logic [REG_ID_BIT-1:0]                    cond_reg [SPEC_DEPTH];
    logic [SPEC_DEPTH-1:0]                    pred_val;
    logic [SPEC_DEPTH-1:0]                    ok, bad, survive, succ;
    logic [SPEC_LEVEL_BIT-1:0]                surv_cnt, dst;
    logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0] nxt_levels;
    logic [IDX_BIT-1:0]                       fail_idx;
    logic                                     fail, push;

    always_comb begin
        for (int e = 0; e < SPEC_DEPTH; e++) begin
            cond_reg[e] = payload_q[e][COND_REG_LSB +: REG_ID_BIT];
            pred_val[e] = payload_q[e][PRED_VAL_LSB];
        end
    end

    spec_wb_match u_match (
        .entry_vld (vld_q),
        .cond_reg  (cond_reg),
        .pred_val  (pred_val),
        .wb_vld    (bus.cond_wb_vld),
        .wb_reg    (bus.cond_wb_reg),
        .wb_val    (bus.cond_wb_val),
        .ok        (ok),
        .bad       (bad)
    );

    // fail accumulates as a running "bad seen at or below e" flag.
    always_comb begin
        surv_cnt   = '0;
        fail       = 1'b0;
        fail_idx   = '0;
        nxt_levels = '0;
        survive    = '0;
        succ       = '0;
        for (int e = 0; e < SPEC_DEPTH; e++) begin
            if (bad[e] && !fail) fail_idx = IDX_BIT'(e);
            fail       = fail | bad[e];
            survive[e] = vld_q[e] & ~ok[e] & ~fail;
            succ[e]    = ok[e] & ~fail;
            if (survive[e]) begin
                surv_cnt = surv_cnt + 1'b1;
                nxt_levels[(e+1)*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT] = surv_cnt;
            end
        end
    end

    assign bus.cur_spec_level          = surv_cnt;
    assign bus.br_pred_succ_vld        = |succ;
    assign bus.br_pred_succ_nxt_levels = nxt_levels;
    assign bus.br_pred_fail            = fail;
    assign bus.br_pred_fail_level      = fail ? SPEC_LEVEL_BIT'(fail_idx) + 1'b1 : '0;
    assign bus.br_pred_fail_pc         = payload_q[fail_idx][PC_LSB +: PC_BIT];
    assign bus.br_pred_fail_id         = payload_q[fail_idx][ID_LSB +: INST_ID_BIT];
    assign bus.br_pred_fail_tag_map    = payload_q[fail_idx][TAG_MAP_LSB +: TAG_MAP_BIT];
    assign bus.br_rdy = ~fail & ~bus.flush & (surv_cnt < SPEC_LEVEL_BIT'(SPEC_DEPTH));
    assign push       = bus.br_vld & bus.br_rdy;

    always_comb begin
        payload_d = payload_q;
        vld_d     = '0;
        dst       = '0;
        for (int e = 0; e < SPEC_DEPTH; e++) begin
            if (survive[e]) begin
                payload_d[dst[IDX_BIT-1:0]] = payload_q[e];
                vld_d[dst[IDX_BIT-1:0]]     = 1'b1;
                dst                         = dst + 1'b1;
            end
        end
        // br_rdy guarantees surv_cnt < SPEC_DEPTH here.
        if (push) begin
            payload_d[surv_cnt[IDX_BIT-1:0]] = pack_entry(bus.br_cond_reg,
                                                          bus.br_cond_predicted_val,
                                                          bus.br_rollback_pc,
                                                          bus.br_rollback_id,
                                                          bus.br_rollback_tag_map);
            vld_d[surv_cnt[IDX_BIT-1:0]] = 1'b1;
        end
        if (bus.flush) vld_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
        payload_q <= payload_d;
    end

endmodule

// File: tb/tb_spec_vector_mw.sv
// Directed scoreboard bench: the driver queues expected outputs, a negedge monitor checks them.
module tb_spec_vector_mw;
    import spec_vector_mw_pkg::*;

    localparam int X = -1;

    typedef struct {
        logic [95:0] name;
        logic        rdy;
        int          lvl;
        logic        succ;
        logic        fail;
        int          flvl;
        int          freg;
        int          n1, n2, n3, n4;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t cur;

    spec_vector_mw_if bus ();

    spec_vector_mw dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] pc_of(input int r);
        return 4'(r + 3);
    endfunction

    function automatic logic [7:0] id_of(input int r);
        return 8'(16 + r);
    endfunction

    function automatic logic [11:0] tag_of(input int r);
        logic [2:0] r3;
        r3 = 3'(r);
        return {r3, r3, r3, r3};
    endfunction

    task automatic chk(input logic [95:0] name, input logic [95:0] field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %0s.%0s actual=%0h required=%0h", name, field, act, exp);
        end
    endtask

    task automatic chk_slot(input logic [95:0] name, input int k, input int exp);
        if (exp >= 0) chk(name, "nxt_level", 32'(bus.br_pred_succ_nxt_levels[k*3 +: 3]), 32'(exp));
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk(cur.name, "br_rdy", 32'(bus.br_rdy), 32'(cur.rdy));
            chk(cur.name, "cur_level", 32'(bus.cur_spec_level), 32'(cur.lvl));
            chk(cur.name, "succ_vld", 32'(bus.br_pred_succ_vld), 32'(cur.succ));
            chk(cur.name, "fail", 32'(bus.br_pred_fail), 32'(cur.fail));
            chk(cur.name, "fail_level", 32'(bus.br_pred_fail_level), 32'(cur.flvl));
            chk_slot(cur.name, 0, 0);
            chk_slot(cur.name, 1, cur.n1);
            chk_slot(cur.name, 2, cur.n2);
            chk_slot(cur.name, 3, cur.n3);
            chk_slot(cur.name, 4, cur.n4);
            if (cur.fail) begin
                chk(cur.name, "fail_pc", 32'(bus.br_pred_fail_pc), 32'(pc_of(cur.freg)));
                chk(cur.name, "fail_id", 32'(bus.br_pred_fail_id), 32'(id_of(cur.freg)));
                chk(cur.name, "fail_tag", 32'(bus.br_pred_fail_tag_map), 32'(tag_of(cur.freg)));
            end
        end
    end

    task automatic expect_c(input logic [95:0] name, input logic rdy, input int lvl,
                            input logic succ, input logic fail, input int flvl, input int freg,
                            input int n1, input int n2, input int n3, input int n4);
        exp_t e;
        e.name = name; e.rdy = rdy; e.lvl = lvl; e.succ = succ; e.fail = fail;
        e.flvl = flvl; e.freg = freg; e.n1 = n1; e.n2 = n2; e.n3 = n3; e.n4 = n4;
        sb.push_back(e);
    endtask

    task automatic idle();
        bus.flush                 = 1'b0;
        bus.br_vld                = 1'b0;
        bus.br_cond_reg           = '0;
        bus.br_cond_predicted_val = 1'b0;
        bus.br_rollback_pc        = '0;
        bus.br_rollback_id        = '0;
        bus.br_rollback_tag_map   = '0;
        bus.cond_wb_vld           = '0;
        bus.cond_wb_reg           = '0;
        bus.cond_wb_val           = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push(input int r, input logic p);
        bus.br_vld                = 1'b1;
        bus.br_cond_reg           = 3'(r);
        bus.br_cond_predicted_val = p;
        bus.br_rollback_pc        = pc_of(r);
        bus.br_rollback_id        = id_of(r);
        bus.br_rollback_tag_map   = tag_of(r);
    endtask

    task automatic wb(input int ch, input int r, input logic v);
        bus.cond_wb_vld[ch]         = 1'b1;
        bus.cond_wb_reg[ch*3 +: 3]  = 3'(r);
        bus.cond_wb_val[ch]         = v;
    endtask

    // Pushes r1..rn, all predicted 1, into an empty stack.
    task automatic fill(input int n);
        for (int r = 1; r <= n; r++) begin
            push(r, 1'b1);
            expect_c("fill", 1, r - 1, 0, 0, 0, 0, X, X, X, X);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_c("reset", 1, 0, 0, 0, 0, 0, X, X, X, X); tick();

        // Two entries, oldest resolves correctly.
        push(1, 1'b1); expect_c("t1_push1", 1, 0, 0, 0, 0, 0, X, X, X, X); tick();
        push(2, 1'b0); expect_c("t1_push2", 1, 1, 0, 0, 0, 0, X, X, X, X); tick();
        wb(0, 1, 1'b1); expect_c("t1_wb", 1, 1, 1, 0, 0, 0, X, 1, X, X); tick();
        expect_c("t1_hold", 1, 1, 0, 0, 0, 0, X, X, X, X); tick();
        wb(0, 2, 1'b1); expect_c("t1_chk", 0, 0, 0, 1, 1, 2, X, X, X, X); tick();
        expect_c("t1_empty", 1, 0, 0, 0, 0, 0, X, X, X, X); tick();

        // Two successes in one cycle.
        fill(4);
        expect_c("t2_full", 0, 4, 0, 0, 0, 0, X, X, X, X); tick();
        wb(0, 2, 1'b1); wb(1, 4, 1'b1);
        expect_c("t2_wb", 1, 2, 1, 0, 0, 0, 1, X, 2, X); tick();
        wb(0, 3, 1'b0); expect_c("t2_chk", 0, 1, 0, 1, 2, 3, 1, X, X, X); tick();
        wb(0, 1, 1'b1); expect_c("t2_clr", 1, 0, 1, 0, 0, 0, X, X, X, X); tick();

        // Fail at entry 2 with an older success in the same cycle.
        fill(4);
        wb(0, 3, 1'b0); wb(1, 1, 1'b1);
        expect_c("t3_fail", 0, 1, 1, 1, 3, 3, X, 1, X, X); tick();
        wb(0, 2, 1'b1); expect_c("t3_chk", 1, 0, 1, 0, 0, 0, X, X, X, X); tick();

        // Full-stack back-pressure, then push alongside a freeing success.
        fill(4);
        push(5, 1'b1); expect_c("t4_full", 0, 4, 0, 0, 0, 0, X, X, X, X); tick();
        wb(0, 1, 1'b1); push(6, 1'b0);
        expect_c("t4_swap", 1, 3, 1, 0, 0, 0, X, 1, 2, 3); tick();
        wb(0, 6, 1'b1); wb(1, 5, 1'b1);
        expect_c("t4_chk", 0, 3, 0, 1, 4, 6, 1, 2, 3, X); tick();
        wb(0, 2, 1'b0); expect_c("t4_clr", 0, 0, 0, 1, 1, 2, X, X, X, X); tick();

        // Same register on both channels: channel 0 decides.
        push(2, 1'b1); expect_c("t5_push", 1, 0, 0, 0, 0, 0, X, X, X, X); tick();
        wb(0, 2, 1'b1); wb(1, 2, 1'b0);
        expect_c("t5_prio", 1, 0, 1, 0, 0, 0, X, X, X, X); tick();
        expect_c("t5_empty", 1, 0, 0, 0, 0, 0, X, X, X, X); tick();

        // Flush with a simultaneous push, then reset while a fail is pending.
        fill(3);
        bus.flush = 1'b1; push(4, 1'b1);
        expect_c("t6_flush", 0, 3, 0, 0, 0, 0, X, X, X, X); tick();
        expect_c("t6_after", 1, 0, 0, 0, 0, 0, X, X, X, X); tick();
        push(1, 1'b1); expect_c("t6_push", 1, 0, 0, 0, 0, 0, X, X, X, X); tick();
        push(3, 1'b1); expect_c("t6_push2", 1, 1, 0, 0, 0, 0, X, X, X, X); tick();
        wb(0, 3, 1'b0); rst_n = 1'b0;
        expect_c("t6_rstfail", 0, 1, 0, 1, 2, 3, 1, X, X, X); tick();
        rst_n = 1'b1;
        expect_c("t6_rst", 1, 0, 0, 0, 0, 0, X, X, X, X); tick();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
